// File: rtl/axis_bram_master_pkg.sv
// Shared FFT datapath widths, plus the types used by the result-BRAM AXIS master.
// Widths come from the macros so the ingress block and this master agree on the lane layout.
`ifndef FFT_DEFS_VH
`define FFT_DEFS_VH
`define ADDR_WIDTH 12
`define DATA_WIDTH 32
`define AXI_WIDTH 64
`define BYTE_COUNT 8
`define AXIS_LANE_WIDTH (`AXI_WIDTH/2)
`endif

package axis_bram_master_pkg;
  localparam int FFT_SIZE_DEF     = 1 << `ADDR_WIDTH;
  localparam int SAMPLE_WIDTH_DEF = `DATA_WIDTH / 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;
endpackage

// File: rtl/axis_skid_fifo.sv
// 2-entry first-word-fall-through FIFO with async reset; head is valid whenever !empty.
// Pop is ignored when empty; push and pop may coincide at any occupancy.
module axis_skid_fifo #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] entry0, entry1;
  logic             pop_ok, push_ok;

  assign empty   = (count == 2'd0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & ((count != 2'd2) | pop_ok);
  assign head    = entry0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= 2'd0;
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) entry0 <= push_data;
          else               entry1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: the incoming word lands behind whatever survives the pop.
          if (count == 2'd1) begin
            entry0 <= push_data;
          end else begin
            entry0 <= entry1;
            entry1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/axis_bram_master.sv
// Streams one FFT frame from the result BRAM (addresses 0..FFT_SIZE-1) onto AXIS, unpacking {imag,real}.
// First beat 3 cycles after go; reads are credited against a 2-entry skid FIFO so tready stalls lose nothing.
module axis_bram_master
  import axis_bram_master_pkg::*;
#(
  parameter int FFT_SIZE     = FFT_SIZE_DEF,
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   axis_bram_master_go,
  output logic                   axis_bram_master_busy,
  output logic                   axis_bram_master_done,
  output logic [`ADDR_WIDTH-1:0] axis_mem2m_raddr,
  output logic                   axis_mem2m_re,
  input  logic [`DATA_WIDTH-1:0] axis_mem2m_rdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [`AXI_WIDTH-1:0]  m_axis_tdata,
  output logic [`BYTE_COUNT-1:0] m_axis_tkeep,
  output logic                   m_axis_tlast
);
  localparam int CW = `ADDR_WIDTH + 1;
  localparam int LW = `AXIS_LANE_WIDTH;
  localparam logic [CW-1:0]          RD_END    = CW'(FFT_SIZE);
  localparam logic [`ADDR_WIDTH-1:0] LAST_ADDR = `ADDR_WIDTH'(FFT_SIZE - 1);

  state_t                   state, state_nxt;
  logic                     start, finish;
  logic [CW-1:0]            rd_cnt;
  logic                     inflight;
  logic [`ADDR_WIDTH-1:0]   inflight_addr;
  logic                     pop;
  logic [2:0]               occ;
  logic                     fifo_empty;
  logic [1:0]               fifo_count;
  logic [`DATA_WIDTH:0]     fifo_head;
  logic [SAMPLE_WIDTH-1:0]  head_real, head_imag;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (axis_bram_master_go) begin
          state_nxt = ST_STREAM;
          start     = 1'b1;
        end
      end
      ST_STREAM: begin
        if (pop && m_axis_tlast) begin
          state_nxt = ST_IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Credit check counts the word already in flight from the BRAM, net of this cycle's pop.
  assign pop   = m_axis_tvalid & m_axis_tready;
  assign occ   = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign axis_mem2m_re    = (state == ST_STREAM) && (rd_cnt < RD_END) && (occ < 3'(FIFO_DEPTH));
  assign axis_mem2m_raddr = rd_cnt[`ADDR_WIDTH-1:0];
  assign axis_bram_master_busy = (state == ST_STREAM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt                <= '0;
      inflight              <= 1'b0;
      inflight_addr         <= '0;
      axis_bram_master_done <= 1'b0;
    end else begin
      axis_bram_master_done <= finish;
      inflight              <= axis_mem2m_re;
      if (axis_mem2m_re) inflight_addr <= axis_mem2m_raddr;
      if (start)              rd_cnt <= '0;
      else if (axis_mem2m_re) rd_cnt <= rd_cnt + CW'(1);
    end
  end

  axis_skid_fifo #(
    .WIDTH(`DATA_WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight),
    .push_data({inflight_addr == LAST_ADDR, axis_mem2m_rdata}),
    .pop      (pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign head_real     = fifo_head[SAMPLE_WIDTH-1:0];
  assign head_imag     = fifo_head[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH];
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tlast  = m_axis_tvalid & fifo_head[`DATA_WIDTH];
  assign m_axis_tkeep  = '1;
  assign m_axis_tdata  = {{(LW-SAMPLE_WIDTH){head_imag[SAMPLE_WIDTH-1]}}, head_imag,
                          {(LW-SAMPLE_WIDTH){head_real[SAMPLE_WIDTH-1]}}, head_real};
endmodule

// File: tb/tb_axis_bram_master.sv
// Directed bench for axis_bram_master: ramp frame, backpressure, go-while-busy, mid-frame reset, sign extension.
module tb_axis_bram_master;
  import axis_bram_master_pkg::*;
  localparam int N = 4096;

  logic clk = 1'b0, reset = 1'b1, go = 1'b0, tready = 1'b0;
  logic busy, done, re, tvalid, tlast;
  logic [`ADDR_WIDTH-1:0] raddr;
  logic [`DATA_WIDTH-1:0] rdata;
  logic [`AXI_WIDTH-1:0]  tdata;
  logic [`BYTE_COUNT-1:0] tkeep;
  logic [31:0] mem [N];

  int passed = 0, total = 0;
  int beats = 0, data_err = 0, tlast_cnt = 0, tlast_err = 0, keep_err = 0;
  int stab_err = 0, re_err = 0, re_cnt = 0, done_cnt = 0, outstanding = 0;
  logic prev_stall = 1'b0, prev_last = 1'b0;
  logic [63:0] prev_data = '0;

  axis_bram_master dut (
    .clk(clk), .reset(reset), .axis_bram_master_go(go),
    .axis_bram_master_busy(busy), .axis_bram_master_done(done),
    .axis_mem2m_raddr(raddr), .axis_mem2m_re(re), .axis_mem2m_rdata(rdata),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
    .m_axis_tkeep(tkeep), .m_axis_tlast(tlast)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (re) rdata <= mem[raddr];

  function automatic logic [63:0] exp_word(input logic [31:0] w);
    return {{16{w[31]}}, w[31:16], {16{w[15]}}, w[15:0]};
  endfunction

  // Scoreboard: samples mid-cycle, restarts its per-frame tallies when a go is accepted.
  always @(negedge clk) begin
    int p;
    if (reset) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (go && !busy) begin
        beats = 0; data_err = 0; tlast_cnt = 0; tlast_err = 0; keep_err = 0;
        stab_err = 0; re_err = 0; re_cnt = 0; done_cnt = 0;
      end
      p = (tvalid && tready) ? 1 : 0;
      if (re && (outstanding - p) >= 2) re_err++;
      if (re) re_cnt++;
      outstanding = outstanding + (re ? 1 : 0) - p;
      if (prev_stall && (!tvalid || tdata !== prev_data || tlast !== prev_last)) stab_err++;
      if (tvalid && tkeep !== 8'hFF) keep_err++;
      if (p == 1) begin
        if (beats >= N || tdata !== exp_word(mem[beats])) data_err++;
        if (tlast !== (beats == N - 1)) tlast_err++;
        if (tlast) tlast_cnt++;
        beats++;
      end
      if (done) done_cnt++;
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  task automatic load_ramp();
    for (int i = 0; i < N; i++) mem[i] = {16'(-i), 16'(i)};
  endtask

  task automatic pulse_go();
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; tready = 1'b0; go = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", tvalid); else passed++;
    total++; if (re !== 1'b0) $display("FAIL reset_re got %b want 0", re); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (raddr !== 12'd0) $display("FAIL reset_raddr got %0d want 0", raddr); else passed++;
    total++; if (tlast !== 1'b0) $display("FAIL reset_tlast got %b want 0", tlast); else passed++;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_ramp();
    int k, first_v, done_k;
    tready = 1'b1;
    pulse_go();
    k = 0; first_v = -1; done_k = -1;
    total++; if (busy !== 1'b1) $display("FAIL ramp_busy_start got %b want 1", busy); else passed++;
    while (k < N + 50 && done_k < 0) begin
      if (tvalid && first_v < 0) first_v = k;
      if (done) done_k = k;
      @(posedge clk); #1; k++;
    end
    repeat (5) @(posedge clk);
    #1;
    total++; if (first_v != 2) $display("FAIL ramp_first_valid got %0d want 2", first_v); else passed++;
    total++; if (done_k != N + 2) $display("FAIL ramp_done_cycle got %0d want %0d", done_k, N + 2); else passed++;
    total++; if (beats != N) $display("FAIL ramp_beats got %0d want %0d", beats, N); else passed++;
    total++; if (data_err != 0) $display("FAIL ramp_data errors got %0d want 0", data_err); else passed++;
    total++; if (tlast_cnt != 1 || tlast_err != 0) $display("FAIL ramp_tlast cnt %0d err %0d want 1/0", tlast_cnt, tlast_err); else passed++;
    total++; if (keep_err != 0) $display("FAIL ramp_tkeep errors got %0d want 0", keep_err); else passed++;
    total++; if (done_cnt != 1) $display("FAIL ramp_done_pulses got %0d want 1", done_cnt); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL ramp_busy_end got %b want 0", busy); else passed++;
  endtask

  task automatic test_random_bp();
    bit ok;
    ok = 1'b0;
    tready = 1'b0;
    pulse_go();
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1 tready = 1'($urandom_range(0, 1));
      if (done_cnt > 0) begin ok = 1'b1; break; end
    end
    tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (!ok) $display("FAIL rand_timeout got no done want done"); else passed++;
    total++; if (beats != N) $display("FAIL rand_beats got %0d want %0d", beats, N); else passed++;
    total++; if (data_err != 0) $display("FAIL rand_data errors got %0d want 0", data_err); else passed++;
    total++; if (tlast_cnt != 1 || tlast_err != 0) $display("FAIL rand_tlast cnt %0d err %0d want 1/0", tlast_cnt, tlast_err); else passed++;
    total++; if (stab_err != 0) $display("FAIL rand_stable errors got %0d want 0", stab_err); else passed++;
    total++; if (re_err != 0) $display("FAIL rand_re_credit errors got %0d want 0", re_err); else passed++;
    total++; if (done_cnt != 1) $display("FAIL rand_done_pulses got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_hold_low();
    bit seen, ok;
    seen = 1'b0;
    tready = 1'b0;
    pulse_go();
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (tvalid) seen = 1'b1;
    end
    repeat (20) @(posedge clk);
    #1;
    total++; if (!seen) $display("FAIL hold_first_valid got none want tvalid"); else passed++;
    total++; if (re_cnt != 2) $display("FAIL hold_reads got %0d want 2", re_cnt); else passed++;
    total++; if (tvalid !== 1'b1) $display("FAIL hold_tvalid got %b want 1", tvalid); else passed++;
    total++; if (tdata !== 64'h0) $display("FAIL hold_word0 got %h want 0", tdata); else passed++;
    total++; if (beats != 0) $display("FAIL hold_beats got %0d want 0", beats); else passed++;
    tready = 1'b1;
    wait_done(N + 50, ok);
    repeat (2) @(posedge clk);
    #1;
    total++; if (!ok) $display("FAIL hold_timeout got no done want done"); else passed++;
    total++; if (beats != N || data_err != 0) $display("FAIL hold_stream beats %0d errors %0d want %0d/0", beats, data_err, N); else passed++;
    total++; if (stab_err != 0) $display("FAIL hold_stable errors got %0d want 0", stab_err); else passed++;
  endtask

  task automatic test_go_busy();
    bit reached, ok;
    reached = 1'b0;
    tready = 1'b1;
    pulse_go();
    for (int i = 0; i < 200 && !reached; i++) begin
      @(posedge clk); #1;
      if (beats >= 100) reached = 1'b1;
    end
    go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
    wait_done(N + 50, ok);
    repeat (20) @(posedge clk);
    #1;
    total++; if (!reached || !ok) $display("FAIL gobusy_progress reached %b done %b want 1/1", reached, ok); else passed++;
    total++; if (done_cnt != 1) $display("FAIL gobusy_done_pulses got %0d want 1", done_cnt); else passed++;
    total++; if (beats != N || tlast_cnt != 1) $display("FAIL gobusy_frame beats %0d tlast %0d want %0d/1", beats, tlast_cnt, N); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL gobusy_busy_end got %b want 0", busy); else passed++;
  endtask

  task automatic test_reset_mid();
    bit reached, ok;
    reached = 1'b0;
    tready = 1'b1;
    pulse_go();
    for (int i = 0; i < 1100 && !reached; i++) begin
      @(posedge clk); #1;
      if (beats >= 1000) reached = 1'b1;
    end
    @(negedge clk); #2 reset = 1'b1;
    #1;
    total++; if (!reached) $display("FAIL rstmid_progress got %0d beats want 1000", beats); else passed++;
    total++; if (tvalid !== 1'b0 || re !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid_async tvalid %b re %b busy %b want 0", tvalid, re, busy); else passed++;
    total++; if (raddr !== 12'd0 || tlast !== 1'b0) $display("FAIL rstmid_raddr got %0d tlast %b want 0/0", raddr, tlast); else passed++;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    total++; if (done_cnt != 0) $display("FAIL rstmid_no_done got %0d want 0", done_cnt); else passed++;
    pulse_go();
    wait_done(N + 50, ok);
    repeat (2) @(posedge clk);
    #1;
    total++; if (!ok) $display("FAIL rstmid_restart_timeout got no done want done"); else passed++;
    total++; if (beats != N || data_err != 0) $display("FAIL rstmid_restart beats %0d errors %0d want %0d/0", beats, data_err, N); else passed++;
    total++; if (tlast_cnt != 1 || tlast_err != 0) $display("FAIL rstmid_tlast cnt %0d err %0d want 1/0", tlast_cnt, tlast_err); else passed++;
  endtask

  task automatic test_sign_edge();
    bit seen, ok;
    seen = 1'b0;
    mem[0] = 32'h7FFF_8000;
    mem[1] = 32'h8000_7FFF;
    tready = 1'b0;
    pulse_go();
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (tvalid) seen = 1'b1;
    end
    total++; if (!seen) $display("FAIL sign_valid got none want tvalid"); else passed++;
    total++; if (tdata[31:0] !== 32'hFFFF8000) $display("FAIL sign_real_lane got %h want ffff8000", tdata[31:0]); else passed++;
    total++; if (tdata[63:32] !== 32'h00007FFF) $display("FAIL sign_imag_lane got %h want 00007fff", tdata[63:32]); else passed++;
    total++; if (tkeep !== 8'hFF) $display("FAIL sign_tkeep got %h want ff", tkeep); else passed++;
    @(posedge clk); #1 tready = 1'b1;
    @(posedge clk); #1 tready = 1'b0;
    total++; if (tdata !== 64'hFFFF8000_00007FFF) $display("FAIL sign_word1 got %h want ffff800000007fff", tdata); else passed++;
    tready = 1'b1;
    wait_done(N + 50, ok);
    repeat (2) @(posedge clk);
    #1;
    total++; if (!ok || data_err != 0) $display("FAIL sign_frame done %b errors %0d want 1/0", ok, data_err); else passed++;
    load_ramp();
  endtask

  initial begin
    load_ramp();
    test_reset();
    test_ramp();
    test_random_bp();
    test_hold_low();
    test_go_busy();
    test_reset_mid();
    test_sign_edge();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
